// File: rtl/switch_ctrl_pkg.sv
// Shared constants and types for the slide-switch input controller.
package switch_ctrl_pkg;

  localparam int DEBOUNCE_W = 16;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_EDGE   = 2'd2;
  localparam logic [1:0] ADDR_CONFIG = 2'd3;

  // Encoding 3 is reserved and behaves like EDGE_BOTH.
  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_e;

  // Terminal count for the debounce counter; limits 0 and 1 both mean one cycle.
  function automatic logic [DEBOUNCE_W-1:0] limit_m1(input logic [DEBOUNCE_W-1:0] l);
    return (l < DEBOUNCE_W'(2)) ? '0 : l - DEBOUNCE_W'(1);
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// One switch bit: 2-flop synchronizer, mismatch counter and qualified stable flop.
module switch_debounce
  import switch_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pin,
  input  logic [DEBOUNCE_W-1:0] limit,
  input  logic                  clr,
  output logic                  stable,
  output logic                  change
);

  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic                  stable_q, stable_d;
  logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = pin;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    // Any cycle of agreement drops back to zero, so only an unbroken run qualifies.
    if (!clr && (sync2_q != stable_q)) begin
      if (cnt_q >= limit_m1(limit)) stable_d = sync2_q;
      else                          cnt_d    = cnt_q + DEBOUNCE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign change = stable_d != stable_q;

endmodule

// File: rtl/switch_input_ctrl.sv
// Avalon-MM slave for the slide-switch bank: debounced DATA, sticky W1C edge
// capture, interrupt mask and debounce/edge-mode configuration.
module switch_input_ctrl
  import switch_ctrl_pkg::*;
#(
  parameter int          WIDTH            = 8,
  parameter logic [15:0] DEBOUNCE_DEFAULT = 16'd50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] in_port
);

  logic [WIDTH-1:0]      stable, change, edge_set, w1c;
  logic [WIDTH-1:0]      mask_q, mask_d;
  logic [WIDTH-1:0]      edge_q, edge_d;
  logic [DEBOUNCE_W-1:0] limit_q, limit_d;
  logic [1:0]            mode_q, mode_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  cfg_wr, rise_en, fall_en;
  logic                  unused_wd;

  assign cfg_wr    = write && (address == ADDR_CONFIG);
  assign unused_wd = ^writedata[31:18];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    switch_debounce u_db (
      .clk    (clk),
      .reset  (reset),
      .pin    (in_port[i]),
      .limit  (limit_q),
      .clr    (cfg_wr),
      .stable (stable[i]),
      .change (change[i])
    );
  end

  assign rise_en  = (mode_q != EDGE_FALL);
  assign fall_en  = (mode_q != EDGE_RISE);
  // stable still holds the old value while change is high.
  assign edge_set = (change & ~stable & {WIDTH{rise_en}}) |
                    (change &  stable & {WIDTH{fall_en}});

  always_comb begin
    mask_d  = mask_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    w1c     = '0;
    rdata_d = rdata_q;
    if (write) begin
      case (address)
        ADDR_MASK:   mask_d = writedata[WIDTH-1:0];
        ADDR_EDGE:   w1c    = writedata[WIDTH-1:0];
        ADDR_CONFIG: begin
          limit_d = writedata[15:0];
          mode_d  = writedata[17:16];
        end
        default: ;
      endcase
    end
    // A new edge in the same cycle as its clear keeps the bit set.
    edge_d = (edge_q & ~w1c) | edge_set;
    if (read) begin
      case (address)
        ADDR_DATA:   rdata_d = 32'(stable);
        ADDR_MASK:   rdata_d = 32'(mask_q);
        ADDR_EDGE:   rdata_d = 32'(edge_q);
        default:     rdata_d = {14'b0, mode_q, limit_q};
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q  <= '0;
      edge_q  <= '0;
      limit_q <= DEBOUNCE_DEFAULT;
      mode_q  <= 2'(EDGE_RISE);
      rdata_q <= '0;
    end else begin
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      rdata_q <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = |(edge_q & mask_q);

endmodule
